alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked ALU. It is the next generation of the team's 16-bit datapath ALU and adds a configurable WIDTH, valid/ready flow control, and flags computed from the current result rather than the previous one. It also adds a stored carry for add/subtract-with-carry chains, signed overflow, rotates, arithmetic shift right, and an iterative multi-cycle multiply. It sits between the instruction-issue stage and the register-file write-back.

## Interface
- WIDTH, 16, operand/result width; legal range 4..64.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  operation request.
- in_ready  out  1  block accepts the request this cycle.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- op_code  in  4  operation select.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result this cycle.
- q_out  out  WIDTH  result.
- carry  out  1  carry, borrow, or shifted-out bit.
- zero  out  1  q_out == 0.
- sign  out  1  q_out[WIDTH-1].
- overflow  out  1  signed overflow.
- parity  out  1  1 when q_out has an even number of ones.

## Operation
- Op codes:
  - 0 ADD a+b; 1 SUB a-b; 2 INC a+1; 3 DEC a-1.
  - 4 SHR logical; 5 SHL; 6 OR; 7 XOR; 8 AND; 9 NOT a.
  - A ADC a+b+c_reg; B SBB a-b-c_reg.
  - C ASR; D ROL by 1; E ROR by 1; F MUL (low WIDTH bits of unsigned a*b).
- Arithmetic is done at WIDTH+1 bits. carry is the bit at position WIDTH. For SUB, DEC and SBB, carry means borrow: 1 when the unsigned result is below 0.
- overflow is signed two's-complement overflow for ops 0-3, A and B. For MUL, carry and overflow are both 1 when the high half of the product is non-zero.
- For SHR, SHL, ASR, ROL and ROR, carry is the bit shifted or rotated out and overflow is 0.
- For ops 6-9, carry and overflow are 0.
- zero, sign and parity are always derived from the q_out value presented with them in the same cycle.
- c_reg is an internal stored carry:
  - It is loaded with carry each time a result is handed off (out_valid && out_ready).
  - ADC and SBB read c_reg as it stands when the instruction is accepted.
  - A dependent ADC issued back-to-back sees the carry of the prior result only if that result was handed off no later than the ADC's accept edge.
- FSM states:
  - IDLE: accepts ops.
  - MUL: shift-add iterations; cnt counts from WIDTH-1 down to 0.
  - OUT: result is held until the handshake completes.
- Transitions:
  - IDLE to MUL on accept of op F.
  - IDLE to OUT on accept of any other op.
  - MUL to OUT when cnt==0.
  - OUT to IDLE on out_ready, unless a new op is accepted in the same cycle, in which case the next state follows that op.
- in_ready = (state==IDLE) || (state==OUT && out_ready).
- A transfer happens only when valid and ready are both high.

## Timing
- Reset values: in_ready=1; out_valid=0; q_out=0; carry, zero, sign, overflow, parity = 0; c_reg=0; state=IDLE.
- Reset in the middle of a MUL or while in OUT discards the operation. No result is emitted.
- Single-cycle ops: accepted at edge N, then out_valid=1 with the result after edge N. Latency is 1.
- Full throughput (one op per cycle) is sustained when out_ready is held at 1.
- MUL: accepted at edge N, then the result is presented after edge N+WIDTH. Latency is WIDTH. in_ready=0 throughout the MUL state.
- Backpressure: while out_valid=1 and out_ready=0, q_out and all flags hold stable and in_ready=0.
- Inputs are sampled only on the accept edge. Operand changes after that edge have no effect.
- A handoff and a new accept in the same cycle are legal. The next result replaces the current one with no bubble.

## Structure
- Package alu_pkg holds the op code localparams (OP_ADD … OP_MUL) and the FSM state encoding.
- Sub-module alu_mul_seq implements the iterative shift-add multiplier:
  - Inputs: start, a, b.
  - Outputs: done, product[2*WIDTH-1:0].
  - It is parametrised by WIDTH.
- The top level contains the single-cycle datapath, the flag logic, c_reg, the FSM and the output register.

## Test plan
- WIDTH=16, ADD 0xFFFF+0x0001 → q_out=0x0000, carry=1, zero=1, overflow=0, parity=1, one cycle after accept.
- SUB 0x0003−0x0005 → q_out=0xFFFE, carry=1, sign=1, overflow=0, parity=0. Then SUB 0x8000−0x0001 → q_out=0x7FFF, overflow=1.
- ADD 0xFFFF+0x0002 handed off, then ADC 0x0000+0x0000 → q_out=0x0001, carry=0.
- MUL 0x0100×0x0100 → q_out=0x0000, carry=1, overflow=1, zero=1, out_valid exactly 16 cycles after accept, in_ready=0 meanwhile. MUL 0x0003×0x0005 → 0x000F.
- out_ready held low for 5 cycles after an OR → outputs stable, in_ready=0. Releasing it with in_valid high gives handoff and accept in the same cycle.
- reset asserted 5 cycles into a MUL → all outputs at reset values next cycle, no spurious out_valid. WIDTH=8 ROL 0x81 → q_out=0x03, carry=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes and FSM encoding for the handshaked ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_INC = 4'h2;
   localparam logic [3:0] OP_DEC = 4'h3;
   localparam logic [3:0] OP_SHR = 4'h4;
   localparam logic [3:0] OP_SHL = 4'h5;
   localparam logic [3:0] OP_OR  = 4'h6;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_AND = 4'h8;
   localparam logic [3:0] OP_NOT = 4'h9;
   localparam logic [3:0] OP_ADC = 4'hA;
   localparam logic [3:0] OP_SBB = 4'hB;
   localparam logic [3:0] OP_ASR = 4'hC;
   localparam logic [3:0] OP_ROL = 4'hD;
   localparam logic [3:0] OP_ROR = 4'hE;
   localparam logic [3:0] OP_MUL = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_OUT  = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               busy;

   assign acc_next = acc + (mplier[0] ? mcand : '0);
   // The final step's sum is exposed combinationally so the caller can latch it on the done edge.
   assign done     = busy && (cnt == '0);
   assign product  = acc_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         acc    <= '0;
         mplier <= b;
         cnt    <= CW'(WIDTH - 1);
         busy   <= 1'b1;
      end else if (busy) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - 1'b1;
         if (cnt == '0) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle datapath, iterative multiply, registered result and flags.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [3:0]       op_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q_out,
   output logic             carry,
   output logic             zero,
   output logic             sign,
   output logic             overflow,
   output logic             parity
);

   localparam int M = WIDTH - 1;

   alu_state_e state, state_nxt;

   logic               accept, handoff, c_reg, c_in, cin_op;
   logic               mul_start, mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   logic [WIDTH-1:0]   b_op, res;
   logic [WIDTH:0]     sum_ext, diff_ext;
   logic               res_c, res_o;

   assign out_valid = (state == ST_OUT);
   assign in_ready  = (state == ST_IDLE) || ((state == ST_OUT) && out_ready);
   assign accept    = in_valid && in_ready;
   assign handoff   = out_valid && out_ready;
   assign mul_start = accept && (op_code == OP_MUL);

   // A result handed off on the same edge as an ADC/SBB accept feeds its carry straight in.
   assign c_in     = handoff ? carry : c_reg;
   assign cin_op   = ((op_code == OP_ADC) || (op_code == OP_SBB)) ? c_in : 1'b0;
   assign b_op     = ((op_code == OP_INC) || (op_code == OP_DEC)) ? WIDTH'(1) : b_in;
   assign sum_ext  = {1'b0, a_in} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin_op};
   assign diff_ext = {1'b0, a_in} - {1'b0, b_op} - {{WIDTH{1'b0}}, cin_op};

   always_comb begin
      res   = '0;
      res_c = 1'b0;
      res_o = 1'b0;
      case (op_code)
         OP_ADD, OP_INC, OP_ADC: begin
            res   = sum_ext[M:0];
            res_c = sum_ext[WIDTH];
            res_o = (a_in[M] == b_op[M]) && (res[M] != a_in[M]);
         end
         OP_SUB, OP_DEC, OP_SBB: begin
            res   = diff_ext[M:0];
            res_c = diff_ext[WIDTH];
            res_o = (a_in[M] != b_op[M]) && (res[M] != a_in[M]);
         end
         OP_SHR: begin res = a_in >> 1;                 res_c = a_in[0]; end
         OP_SHL: begin res = a_in << 1;                 res_c = a_in[M]; end
         OP_ASR: begin res = {a_in[M], a_in[M:1]};      res_c = a_in[0]; end
         OP_ROL: begin res = {a_in[M-1:0], a_in[M]};    res_c = a_in[M]; end
         OP_ROR: begin res = {a_in[0], a_in[M:1]};      res_c = a_in[0]; end
         OP_OR:  res = a_in | b_in;
         OP_XOR: res = a_in ^ b_in;
         OP_AND: res = a_in & b_in;
         OP_NOT: res = ~a_in;
         default: ;
      endcase
   end

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (a_in),
      .b       (b_in),
      .done    (mul_done),
      .product (mul_prod)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = (op_code == OP_MUL) ? ST_MUL : ST_OUT;
         ST_MUL:  if (mul_done) state_nxt = ST_OUT;
         ST_OUT: begin
            if (accept)         state_nxt = (op_code == OP_MUL) ? ST_MUL : ST_OUT;
            else if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_out    <= '0;
         carry    <= 1'b0;
         zero     <= 1'b0;
         sign     <= 1'b0;
         overflow <= 1'b0;
         parity   <= 1'b0;
         c_reg    <= 1'b0;
      end else begin
         if (handoff) c_reg <= carry;
         if (accept && (op_code != OP_MUL)) begin
            q_out    <= res;
            carry    <= res_c;
            overflow <= res_o;
            zero     <= (res == '0);
            sign     <= res[M];
            parity   <= ~^res;
         end else if ((state == ST_MUL) && mul_done) begin
            q_out    <= mul_prod[M:0];
            carry    <= |mul_prod[2*WIDTH-1:WIDTH];
            overflow <= |mul_prod[2*WIDTH-1:WIDTH];
            zero     <= (mul_prod[M:0] == '0);
            sign     <= mul_prod[M];
            parity   <= ~^mul_prod[M:0];
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed ops push expectations, a monitor checks each handoff.
module tb_alu_pipe;

   typedef struct packed {
      logic [15:0] q;
      logic        c, z, s, o, p;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [15:0] a_in = '0, b_in = '0, q_out;
   logic [3:0]  op_code = '0;
   logic        carry, zero, sign, overflow, parity;

   logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
   logic [7:0]  a8 = '0, b8 = '0, q8;
   logic [3:0]  op8 = '0;
   logic        c8, z8, s8, o8, p8;

   int   checks = 0, failures = 0, nres = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .op_code(op_code), .out_valid(out_valid),
      .out_ready(out_ready), .q_out(q_out), .carry(carry), .zero(zero),
      .sign(sign), .overflow(overflow), .parity(parity)
   );

   alu_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
      .a_in(a8), .b_in(b8), .op_code(op8), .out_valid(ov8),
      .out_ready(or8), .q_out(q8), .carry(c8), .zero(z8),
      .sign(s8), .overflow(o8), .parity(p8)
   );

   function automatic exp_t mk(logic [15:0] q, logic c, logic z, logic s, logic o, logic p);
      mk = '{q: q, c: c, z: z, s: s, o: o, p: p};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Called just after a rising edge; returns just after the accept edge.
   task automatic issue(logic [3:0] op, logic [15:0] a, logic [15:0] b, exp_t e, bit push);
      int n;
      if (push) sb.push_back(e);
      op_code = op; a_in = a; b_in = b; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) begin
         checks++; failures++;
         $display("FAIL issue_timeout op=%0h in_ready=%0b", op, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_result q=%0h expected=none", q_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("result%0d", nres), 64'({q_out, carry, zero, sign, overflow, parity}), 64'(e));
            nres++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit bad;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",  64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_q",         64'(q_out), 64'd0);
      chk("rst_flags",     64'({carry, zero, sign, overflow, parity}), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b1;

      issue(4'h0, 16'hFFFF, 16'h0001, mk(16'h0000, 1, 1, 0, 0, 1), 1);
      @(negedge clk);
      chk("add_latency1", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      issue(4'h1, 16'h0003, 16'h0005, mk(16'hFFFE, 1, 0, 1, 0, 0), 1);
      issue(4'h1, 16'h8000, 16'h0001, mk(16'h7FFF, 0, 0, 0, 1, 0), 1);
      issue(4'h0, 16'hFFFF, 16'h0002, mk(16'h0001, 1, 0, 0, 0, 0), 1);
      issue(4'hA, 16'h0000, 16'h0000, mk(16'h0001, 0, 0, 0, 0, 0), 1);
      issue(4'h2, 16'h7FFF, 16'h0000, mk(16'h8000, 0, 0, 1, 1, 0), 1);
      issue(4'h3, 16'h0000, 16'h0000, mk(16'hFFFF, 1, 0, 1, 0, 1), 1);
      issue(4'hC, 16'h8001, 16'h0000, mk(16'hC000, 1, 0, 1, 0, 1), 1);

      // multiply latency and in_ready low while iterating
      issue(4'hF, 16'h0100, 16'h0100, mk(16'h0000, 1, 1, 0, 1, 1), 1);
      lat = 0; bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) break;
         if (in_ready) bad = 1;
         @(posedge clk);
         lat++;
      end
      chk("mul_latency", 64'(lat), 64'd16);
      chk("mul_in_ready_low", 64'(bad), 64'd0);
      @(posedge clk); #1;
      issue(4'hF, 16'h0003, 16'h0005, mk(16'h000F, 0, 0, 0, 0, 1), 1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      @(posedge clk); #1;

      // backpressure: result and flags hold, no new accepts
      out_ready = 1'b0;
      issue(4'h6, 16'h1200, 16'h0034, mk(16'h1234, 0, 0, 0, 0, 0), 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_q",         64'({q_out, carry, zero, sign, overflow, parity}), 64'({16'h1234, 5'b0}));
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_in_ready",  64'(in_ready), 64'd0);
         @(posedge clk); #1;
      end
      sb.push_back(mk(16'hFF00, 0, 0, 1, 0, 1));
      op_code = 4'h7; a_in = 16'hFFFF; b_in = 16'h00FF; in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("handoff_accept_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; a_in = 16'h5555;
      @(negedge clk);
      chk("xor_valid_no_bubble", 64'(out_valid), 64'd1);
      @(posedge clk); #1;

      // reset mid-multiply discards the op and clears the stored carry
      issue(4'h0, 16'hFFFF, 16'h0001, mk(16'h0000, 1, 1, 0, 0, 1), 1);
      issue(4'hF, 16'h1234, 16'h0005, mk(16'h0000, 0, 0, 0, 0, 0), 0);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mrst_in_ready",  64'(in_ready), 64'd1);
      chk("mrst_out_valid", 64'(out_valid), 64'd0);
      chk("mrst_q_flags",   64'({q_out, carry, zero, sign, overflow, parity}), 64'd0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) bad = 1;
      end
      chk("mrst_no_spurious", 64'(bad), 64'd0);
      @(posedge clk); #1;
      issue(4'hA, 16'h0000, 16'h0000, mk(16'h0000, 0, 1, 0, 0, 1), 1);
      repeat (3) @(posedge clk);
      #1;

      // WIDTH=8 rotate
      op8 = 4'hD; a8 = 8'h81; b8 = 8'h00; iv8 = 1'b1;
      @(negedge clk);
      chk("w8_in_ready", 64'(ir8), 64'd1);
      @(posedge clk); #1;
      iv8 = 1'b0;
      @(negedge clk);
      chk("w8_rol", 64'({ov8, q8, c8, z8, s8, o8, p8}), 64'({1'b1, 8'h03, 5'b10001}));
      @(posedge clk); #1;

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
